// File: rtl/ahb_mtx_pkg.sv
// Shared AHB matrix encodings: HTRANS/HBURST codes, burst-remain preload values, arbitration modes.
package ahb_mtx_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  // Beats still to come after the NONSEQ and the first SEQ of a fixed-length burst.
  localparam logic [3:0] REMAIN_16 = 4'd14;
  localparam logic [3:0] REMAIN_8  = 4'd6;
  localparam logic [3:0] REMAIN_4  = 4'd2;

  typedef enum int {
    ARB_RR    = 0,
    ARB_FIXED = 1
  } arb_mode_e;

endpackage

// File: rtl/ahb_mtx_arbiter_param_if.sv
// Request/transfer/grant bundle between the input stages and one output-stage arbiter.
interface ahb_mtx_arbiter_param_if #(
  parameter int NUM_PORTS = 4
) ();
  localparam int PORT_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] req_port;
  logic                 HREADYM;
  logic                 HSELM;
  logic [1:0]           HTRANSM;
  logic [2:0]           HBURSTM;
  logic                 HMASTLOCKM;
  logic [PORT_W-1:0]    addr_in_port;
  logic [NUM_PORTS-1:0] grant_onehot;
  logic                 no_port;

  modport master (
    output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, grant_onehot, no_port
  );

  modport slave (
    input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, grant_onehot, no_port
  );
endinterface

// File: rtl/ahb_mtx_burst_tracker.sv
// Tracks beats left in the current burst and whether the grant must be held; next_burst_hold is
// the combinational next-state of the hold flag. All state advances only when HREADYM is high.
module ahb_mtx_burst_tracker
  import ahb_mtx_pkg::*;
#(
  parameter int INCR_EARLY_MAX = 1
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  output logic       next_burst_hold
);
  logic [3:0] remain_q, remain_d;
  logic       hold_q, hold_d;
  logic [1:0] early_q, early_d, early_inc;

  always_comb begin
    // A NONSEQ arriving while still holding terminates an INCR early and counts itself.
    early_inc = early_q;
    if (hold_q && (HTRANSM == HTRANS_NONSEQ) && (early_q != 2'd3)) begin
      early_inc = early_q + 2'd1;
    end

    remain_d = remain_q;
    hold_d   = hold_q;
    if (!HSELM) begin
      remain_d = '0;
      hold_d   = 1'b0;
    end else begin
      case (htrans_e'(HTRANSM))
        HTRANS_NONSEQ: begin
          case (hburst_e'(HBURSTM))
            HBURST_INCR16, HBURST_WRAP16: begin remain_d = REMAIN_16; hold_d = 1'b1; end
            HBURST_INCR8,  HBURST_WRAP8:  begin remain_d = REMAIN_8;  hold_d = 1'b1; end
            HBURST_INCR4,  HBURST_WRAP4:  begin remain_d = REMAIN_4;  hold_d = 1'b1; end
            HBURST_INCR: begin
              if (int'(early_inc) >= INCR_EARLY_MAX) begin
                remain_d = '0;
                hold_d   = 1'b0;
              end else begin
                remain_d = REMAIN_4;
                hold_d   = 1'b1;
              end
            end
            default: begin remain_d = '0; hold_d = 1'b0; end
          endcase
        end
        HTRANS_SEQ: begin
          if (remain_q == '0) hold_d = 1'b0;
          else                remain_d = remain_q - 4'd1;
        end
        HTRANS_BUSY: begin
          remain_d = remain_q;
        end
        default: begin
          remain_d = '0;
          hold_d   = 1'b0;
        end
      endcase
    end

    early_d = hold_d ? early_inc : 2'd0;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      remain_q <= '0;
      hold_q   <= 1'b0;
      early_q  <= '0;
    end else if (HREADYM) begin
      remain_q <= remain_d;
      hold_q   <= hold_d;
      early_q  <= early_d;
    end
  end

  assign next_burst_hold = hold_d;
endmodule

// File: rtl/ahb_mtx_arbiter_param.sv
// Output-stage arbiter: round-robin or fixed priority, grant held over bursts and locks; the
// decision is registered on HREADYM. Define ARB_STARVE_EN to add per-port starvation override.
module ahb_mtx_arbiter_param
  import ahb_mtx_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int ARB_MODE       = 0,
  parameter int INCR_EARLY_MAX = 1,
  parameter int STARVE_LIMIT   = 8
) (
  input logic                    HCLK,
  input logic                    HRESET,
  ahb_mtx_arbiter_param_if.slave bus
);
  localparam int PORT_W     = $clog2(NUM_PORTS);
  localparam bit FIXED_PRIO = (ARB_MODE == int'(ARB_FIXED));

  logic                 next_hold;
  logic [PORT_W-1:0]    port_q, port_d;
  logic                 no_port_q, no_port_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic                 lo_found, rr_found;
  logic [PORT_W-1:0]    lo_port, rr_port;

  ahb_mtx_burst_tracker #(.INCR_EARLY_MAX(INCR_EARLY_MAX)) u_burst (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .HREADYM         (bus.HREADYM),
    .HSELM           (bus.HSELM),
    .HTRANSM         (bus.HTRANSM),
    .HBURSTM         (bus.HBURSTM),
    .next_burst_hold (next_hold)
  );

  always_comb begin
    int idx;
    idx      = 0;
    lo_found = 1'b0;
    lo_port  = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (bus.req_port[PORT_W'(k)]) begin
        lo_found = 1'b1;
        lo_port  = PORT_W'(k);
      end
    end
    // Round-robin never considers the current owner, so its own request cannot re-win.
    rr_found = 1'b0;
    rr_port  = port_q;
    for (int k = 1; k < NUM_PORTS; k++) begin
      idx = (int'(port_q) + k) % NUM_PORTS;
      if (!rr_found && bus.req_port[PORT_W'(idx)]) begin
        rr_found = 1'b1;
        rr_port  = PORT_W'(idx);
      end
    end
  end

`ifdef ARB_STARVE_EN
  logic [7:0]        wait_q [NUM_PORTS];
  logic [7:0]        wait_d [NUM_PORTS];
  logic              starve_found;
  logic [PORT_W-1:0] starve_port;

  always_comb begin
    starve_found = 1'b0;
    starve_port  = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (bus.req_port[PORT_W'(k)] && (wait_q[k] >= 8'(STARVE_LIMIT))) begin
        starve_found = 1'b1;
        starve_port  = PORT_W'(k);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      wait_d[k] = wait_q[k];
      if (!bus.req_port[PORT_W'(k)] || (!no_port_d && (port_d == PORT_W'(k)))) begin
        wait_d[k] = '0;
      end else if (wait_q[k] != 8'hFF) begin
        wait_d[k] = wait_q[k] + 8'd1;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int k = 0; k < NUM_PORTS; k++) wait_q[k] <= '0;
    end else if (bus.HREADYM) begin
      for (int k = 0; k < NUM_PORTS; k++) wait_q[k] <= wait_d[k];
    end
  end
`endif

  always_comb begin
    port_d    = port_q;
    no_port_d = no_port_q;
    if (bus.HMASTLOCKM || next_hold) begin
      port_d    = port_q;
      no_port_d = no_port_q;
    end
`ifdef ARB_STARVE_EN
    else if (starve_found) begin
      port_d    = starve_port;
      no_port_d = 1'b0;
    end
`endif
    else if (no_port_q) begin
      if (lo_found) begin
        port_d    = lo_port;
        no_port_d = 1'b0;
      end
    end else if (FIXED_PRIO) begin
      if (lo_found)        port_d    = lo_port;
      else if (!bus.HSELM) no_port_d = 1'b1;
    end else begin
      if (rr_found)        port_d    = rr_port;
      else if (!bus.HSELM) no_port_d = 1'b1;
    end

    grant_d = '0;
    if (!no_port_d) grant_d[port_d] = 1'b1;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      port_q    <= '0;
      no_port_q <= 1'b1;
      grant_q   <= '0;
    end else if (bus.HREADYM) begin
      port_q    <= port_d;
      no_port_q <= no_port_d;
      grant_q   <= grant_d;
    end
  end

  assign bus.addr_in_port = port_q;
  assign bus.grant_onehot = grant_q;
  assign bus.no_port      = no_port_q;
endmodule

// File: tb/tb_ahb_mtx_arbiter_param.sv
// Directed bench: a round-robin arbiter and a fixed-priority arbiter driven by the same stimulus.
module tb_ahb_mtx_arbiter_param;
  import ahb_mtx_pkg::*;

  logic HCLK = 1'b0;
  logic HRESET;
  int   n_tests = 0;
  int   n_fail  = 0;

  ahb_mtx_arbiter_param_if #(.NUM_PORTS(4)) ifa ();
  ahb_mtx_arbiter_param_if #(.NUM_PORTS(4)) ifb ();

  assign ifb.req_port   = ifa.req_port;
  assign ifb.HREADYM    = ifa.HREADYM;
  assign ifb.HSELM      = ifa.HSELM;
  assign ifb.HTRANSM    = ifa.HTRANSM;
  assign ifb.HBURSTM    = ifa.HBURSTM;
  assign ifb.HMASTLOCKM = ifa.HMASTLOCKM;

  ahb_mtx_arbiter_param #(
    .NUM_PORTS(4), .ARB_MODE(0), .INCR_EARLY_MAX(1), .STARVE_LIMIT(255)
  ) dut_rr (
    .HCLK(HCLK), .HRESET(HRESET), .bus(ifa)
  );

  ahb_mtx_arbiter_param #(
    .NUM_PORTS(4), .ARB_MODE(1), .INCR_EARLY_MAX(1), .STARVE_LIMIT(3)
  ) dut_fp (
    .HCLK(HCLK), .HRESET(HRESET), .bus(ifb)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic np, input int port);
    chk({tag, ".no_port"}, 32'(ifa.no_port), 32'(np));
    chk({tag, ".port"}, 32'(ifa.addr_in_port), 32'(port));
    chk({tag, ".onehot"}, 32'(ifa.grant_onehot), np ? 32'd0 : (32'd1 << port));
  endtask

  task automatic chk_b(input string tag, input logic np, input int port);
    chk({tag, ".no_port"}, 32'(ifb.no_port), 32'(np));
    chk({tag, ".port"}, 32'(ifb.addr_in_port), 32'(port));
    chk({tag, ".onehot"}, 32'(ifb.grant_onehot), np ? 32'd0 : (32'd1 << port));
  endtask

  task automatic drv(input logic [3:0] req, input logic rdy, input logic sel,
                     input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    ifa.req_port   = req;
    ifa.HREADYM    = rdy;
    ifa.HSELM      = sel;
    ifa.HTRANSM    = tr;
    ifa.HBURSTM    = bu;
    ifa.HMASTLOCKM = lk;
  endtask

  int exp_a [5] = '{0, 3, 0, 3, 0};
`ifdef ARB_STARVE_EN
  int exp_b [5] = '{0, 0, 0, 3, 0};
`else
  int exp_b [5] = '{0, 0, 0, 0, 0};
`endif

  initial begin
    HRESET = 1'b1;
    drv(4'b0000, 1'b1, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick();
    tick();
    chk_a("reset", 1'b1, 0);
    chk_b("reset_fp", 1'b1, 0);
    HRESET = 1'b0;
    tick();
    chk_a("idle", 1'b1, 0);

    drv(4'b0100, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick();
    chk_a("first_grant", 1'b0, 2);
    drv(4'b1000, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick();
    chk_a("to3", 1'b0, 3);

    // Round-robin rotation from port 3 wraps to port 0.
    drv(4'b1111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a($sformatf("rr%0d", i), 1'b0, i % 4);
    end
    tick();
    chk_a("to1", 1'b0, 1);

    // INCR8 from port 1 with a BUSY and a two-cycle wait state.
    drv(4'b1111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR8, 1'b0);
    tick();
    chk_a("b8_ns", 1'b0, 1);
    drv(4'b1111, 1'b1, 1'b1, HTRANS_SEQ, HBURST_INCR8, 1'b0);
    tick();
    chk_a("b8_s1", 1'b0, 1);
    tick();
    chk_a("b8_s2", 1'b0, 1);
    drv(4'b1111, 1'b1, 1'b1, HTRANS_BUSY, HBURST_INCR8, 1'b0);
    tick();
    chk_a("b8_busy", 1'b0, 1);
    drv(4'b1111, 1'b0, 1'b1, HTRANS_SEQ, HBURST_INCR8, 1'b0);
    tick();
    chk_a("b8_wait0", 1'b0, 1);
    tick();
    chk_a("b8_wait1", 1'b0, 1);
    drv(4'b1111, 1'b1, 1'b1, HTRANS_SEQ, HBURST_INCR8, 1'b0);
    for (int i = 3; i < 7; i++) begin
      tick();
      chk_a($sformatf("b8_s%0d", i), 1'b0, 1);
    end
    tick();
    chk_a("b8_end", 1'b0, 2);

    // HREADYM low freezes the grant even when arbitration would move it.
    drv(4'b1111, 1'b0, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick();
    chk_a("freeze0", 1'b0, 2);
    tick();
    chk_a("freeze1", 1'b0, 2);

    // Back-to-back 2-beat INCR from port 1 with port 0 competing.
    drv(4'b0011, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick();
    chk_a("rr_wrap0", 1'b0, 0);
    tick();
    chk_a("rr_p1", 1'b0, 1);
    drv(4'b0011, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR, 1'b0);
    tick();
    chk_a("incr_ns1", 1'b0, 1);
    drv(4'b0011, 1'b1, 1'b1, HTRANS_SEQ, HBURST_INCR, 1'b0);
    tick();
    chk_a("incr_s1", 1'b0, 1);
    drv(4'b0011, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR, 1'b0);
    tick();
    chk_a("incr_ns2", 1'b0, 0);

    // Locked sequence holds port 0 for five edges.
    drv(4'b1111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a($sformatf("lock%0d", i), 1'b0, 0);
    end
    drv(4'b1111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick();
    chk_a("unlock", 1'b0, 1);

    drv(4'b0000, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick();
    chk_a("keep_sel", 1'b0, 1);
    drv(4'b0000, 1'b1, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick();
    chk_a("nosel0", 1'b1, 1);
    tick();
    chk_a("nosel1", 1'b1, 1);
    drv(4'b1001, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick();
    chk_a("noport_lowest", 1'b0, 0);

    // Reset in the middle of an INCR16 abandons the burst.
    drv(4'b1111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR16, 1'b0);
    tick();
    chk_a("inc16_hold", 1'b0, 0);
    HRESET = 1'b1;
    #2;
    chk_a("arst", 1'b1, 0);
    chk_b("arst_fp", 1'b1, 0);
    #1;
    HRESET = 1'b0;
    drv(4'b1001, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a($sformatf("post_rr%0d", i), 1'b0, exp_a[i]);
      chk_b($sformatf("post_fp%0d", i), 1'b0, exp_b[i]);
`ifdef ARB_STARVE_EN
      if (i == 3) chk("fp_wait3", 32'(dut_fp.wait_q[3]), 32'd0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
